bus_arbiter_4: RTL and testbench

BUS_ARBITER_4 -- requirements
Module: bus_arbiter_4

---
 rtl/bus_arbiter_4.sv | 87 ++++++++
 tb/tb_bus_arbiter_4.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_4.sv
// Four-requester round-robin arbiter for a shared resource behind a 4:1 mux.
// One grant is held until done, an abort by the owner, or an optional timeout.
//
// state | meaning
// IDLE  | no grant; arbitrate among pending requests on the next edge
// BUSY  | exactly one grant held; wait for done, abort or timeout
module bus_arbiter_4 #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [3:0] req_i,
  input  logic       done_i,
  output logic [3:0] grant_o,
  output logic [1:0] select_o,
  output logic       busy_o,
  output logic       timeout_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state;
  logic [1:0]    last_owner;
  logic [CW-1:0] cnt;
  logic [1:0]    winner;
  logic          rel_abort;
  logic          rel_timeout;
  logic          release_now;

  // Scan downward in offset so the nearest requester after last_owner wins.
  always_comb begin
    winner = last_owner;
    for (int i = 4; i >= 1; i--) begin
      if (req_i[last_owner + 2'(i)]) winner = last_owner + 2'(i);
    end
  end

  assign rel_abort   = ~req_i[select_o];
  assign rel_timeout = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
  assign release_now = done_i | rel_abort | rel_timeout;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      grant_o    <= 4'b0000;
      select_o   <= 2'd0;
      busy_o     <= 1'b0;
      timeout_o  <= 1'b0;
      cnt        <= '0;
      last_owner <= 2'd3;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_i) begin
            state    <= BUSY;
            grant_o  <= 4'b0001 << winner;
            select_o <= winner;
            busy_o   <= 1'b1;
            cnt      <= '0;
          end
        end
        BUSY: begin
          if (release_now) begin
            state      <= IDLE;
            grant_o    <= 4'b0000;
            busy_o     <= 1'b0;
            last_owner <= select_o;
            // done takes precedence over a coincident timeout
            timeout_o  <= rel_timeout & ~done_i;
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_4.sv
// Directed bench for bus_arbiter_4 with a cycle-level reference model of the
// arbitration rules, plus a TIMEOUT_CYCLES=0 instance for the no-timeout case.
module tb_bus_arbiter_4;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;

  logic [3:0] grant, grant0;
  logic [1:0] sel, sel0;
  logic       busy, busy0, tout, tout0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_arbiter_4 #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rstn_i(rstn), .req_i(req), .done_i(done),
    .grant_o(grant), .select_o(sel), .busy_o(busy), .timeout_o(tout)
  );

  bus_arbiter_4 #(.TIMEOUT_CYCLES(0)) dut0 (
    .clk_i(clk), .rstn_i(rstn), .req_i(req), .done_i(done),
    .grant_o(grant0), .select_o(sel0), .busy_o(busy0), .timeout_o(tout0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: owner index (-1 when nobody holds the bus), cycles held so far.
  int m_owner = -1;
  int m_last  = 3;
  int m_sel   = 0;
  int m_age   = 0;
  bit m_to    = 1'b0;
  bit m_d, m_a, m_t, m_found;
  bit chk_en  = 1'b0;

  always @(posedge clk) begin
    if (!rstn) begin
      m_owner = -1; m_last = 3; m_sel = 0; m_age = 0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      m_found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        if (!m_found && req[(m_last + k) % 4]) begin
          m_owner = (m_last + k) % 4;
          m_found = 1'b1;
        end
      end
      if (m_found) begin
        m_sel = m_owner;
        m_age = 0;
      end
    end else begin
      m_d = done;
      m_a = !req[m_owner];
      m_t = (TO > 0) && (m_age + 1 >= TO);
      if (m_d || m_a || m_t) begin
        m_last  = m_owner;
        m_owner = -1;
        m_to    = m_t && !m_d;
      end else begin
        m_age++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_grant",   grant, (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      check("model_select",  sel,   m_sel);
      check("model_busy",    busy,  (m_owner >= 0) ? 32'd1 : 32'd0);
      check("model_timeout", tout,  m_to);
      check("nto_timeout_low", tout0, 32'd0);
    end
  end

  logic [3:0] exp_g [9];
  logic [1:0] exp_s [5];
  int gcnt, g0cnt, pcnt;

  initial begin
    exp_g = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
              4'b0000, 4'b1000, 4'b0000, 4'b0001};
    exp_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // reset
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_select", sel, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", tout, 0);
    chk_en = 1'b1;
    rstn = 1'b1;

    // done in IDLE with no requests
    req = 4'b0000; done = 1'b1;
    @(negedge clk);
    check("idle_done_grant", grant, 0);
    check("idle_done_busy", busy, 0);
    check("idle_done_timeout", tout, 0);

    // round robin with all requesting, done one cycle after each grant
    req = 4'b1111; done = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("rr_grant", grant, exp_g[i]);
      if (i % 2 == 0) check("rr_select", sel, exp_s[i / 2]);
      done = (exp_g[i] != 4'b0000);
    end
    @(negedge clk);
    req = 4'b0000; done = 1'b0;

    // lone requester 2 never gets done: timeout after 16 cycles
    @(negedge clk);
    req = 4'b0100;
    gcnt = 0; g0cnt = 0; pcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (grant == 4'b0100) gcnt++;
      if (grant0 == 4'b0100) g0cnt++;
      if (tout) begin
        pcnt++;
        check("to_grant_dropped", grant, 0);
        req = 4'b0000;
      end
    end
    check("to_grant_cycles", gcnt, 16);
    check("to_pulse_count", pcnt, 1);
    check("nto_hold_cycles", g0cnt, 17);

    // owner 1 aborts while requester 3 waits
    req = 4'b0010;
    @(negedge clk);
    check("abort_owner_grant", grant, 4'b0010);
    req = 4'b1010;
    @(negedge clk);
    check("other_req_ignored", grant, 4'b0010);
    req = 4'b1000;
    @(negedge clk);
    check("abort_release_grant", grant, 0);
    check("abort_no_timeout", tout, 0);
    @(negedge clk);
    check("after_abort_grant", grant, 4'b1000);
    check("after_abort_select", sel, 3);
    done = 1'b1;
    @(negedge clk);
    check("after_abort_done", grant, 0);
    done = 1'b0; req = 4'b0000;

    // done on the cycle the counter reaches its last value
    @(negedge clk);
    req = 4'b0001;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 16) begin
        check("done_at_last_hold", grant, 4'b0001);
        done = 1'b1;
      end
    end
    @(negedge clk);
    check("done_at_last_grant", grant, 0);
    check("done_at_last_timeout", tout, 0);
    check("done_at_last_busy", busy, 0);
    done = 1'b0; req = 4'b0000;

    // reset during a grant, then re-arbitrate with priority restored
    @(negedge clk);
    req = 4'b1010;
    @(negedge clk);
    check("pre_reset_grant", grant, 4'b0010);
    rstn = 1'b0;
    @(negedge clk);
    check("mid_reset_grant", grant, 0);
    check("mid_reset_select", sel, 0);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_timeout", tout, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("post_reset_grant", grant, 4'b0010);
    check("post_reset_select", sel, 1);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0; req = 4'b0000;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
